dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
- Load/store unit that sits directly upstream of the word-only data memory.
- Takes MIPS memory ops (LB/LBU/LH/LHU/LW/SB/SH/SW) from the MEM stage and drives the word-wide memory port: read enable, write enable, word-aligned address, write data.
- Performs byte-lane extraction with sign/zero extension on loads and read-modify-write (RMW) merging for sub-word stores.
- Flags misaligned accesses instead of issuing them.

Parameters:
ADDR_W, 32, width of request and memory address buses
STAT_W, 32, width of statistics counters (used only with LSU_STATS_EN)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle and accepting; transfer when req_valid&req_ready at CLK edge
req_op  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_rdata  out  32  load result (0 for stores and errors)
resp_err  out  1  misaligned access, valid with resp_valid
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable, committed at CLK edge
mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data from memory
stat_loads, stat_stores, stat_errs  out  STAT_W  each  counters (see Optional Feature)

Behaviour:
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]; half lane selected by addr[1].
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
- Reset: state=IDLE; all request registers = 0; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_re=0; mem_we=0; mem_addr=0; mem_wdata=0.
- IDLE: req_ready=1. On accept, latch op, addr and wdata, then branch:
  - misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> RESP with err=1. No memory access.
  - load -> RD
  - SW -> WR, with the merge register set to wdata
  - SB/SH -> RMW_RD
- RD: mem_re=1. At the edge, register the extracted lane into resp_rdata (LB/LH sign-extend; LBU/LHU zero-extend; LW whole word). -> RESP.
- RMW_RD: mem_re=1. At the edge, the merge register takes mem_rdata with the addressed byte/half lane replaced by wdata[7:0]/[15:0]. -> WR.
- WR: mem_we=1, mem_wdata = merge register. -> RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0. -> IDLE.
- mem_re, mem_we and mem_addr decode from registered state only; no combinational path from req_* to mem_*.
- Latency, counted in cycles after the accept edge with resp_valid high: misaligned 1; load 2; SW 2; SB/SH 3. Throughput: one op per latency+1 cycles.
- mem_re and mem_we are never both high.
- mem_addr holds its last value outside RD/RMW_RD/WR. Enables are 0 outside those states.
- RMW window is atomic with respect to this unit; there is no other memory master.
- req_valid while busy: ignored, since req_ready=0. The requester holds the request.
- Reset asserted mid-operation: immediate return to IDLE, and mem_we drops asynchronously. A store is committed only if the WR-state edge occurred before reset assertion. No resp_valid is issued for the aborted op.
- Address beyond memory range: passed through unchanged; range checking is the memory's job.

Optional Feature:
- Macro LSU_STATS_EN.
- Defined:
  - stat_loads increments on each completed load.
  - stat_stores increments on each completed store.
  - stat_errs increments on each misaligned response.
  - Each counter updates on the RESP cycle, wraps at 2^STAT_W and resets to 0.
- Undefined: the counters are not built and all three outputs are tied to 0.

Test Plan:
- Memory word 0x100 = 0x80FF7F01. LB 0x101 -> resp_rdata 0x0000007F. LB 0x103 -> 0xFFFFFF80. LBU 0x103 -> 0x00000080. Each has resp_valid exactly 2 cycles after accept.
- LH 0x102 on the same word -> 0xFFFF80FF. LHU 0x100 -> 0x00007F01. LW 0x100 -> 0x80FF7F01.
- SB 0x102 with wdata 0x000000AA on word 0x12345678:
  - sequence is mem_re cycle, then mem_we cycle with mem_wdata 0x12AA5678;
  - resp_valid 3 cycles after accept;
  - a following LW returns 0x12AA5678.
- SH 0x101 -> resp_err=1, resp_valid 1 cycle after accept, mem_re=mem_we=0 throughout. LW 0x102 behaves the same.
- Assert RST_N=0 during WR of SW 0x200 = 0xDEADBEEF, before the edge -> mem_we falls immediately, word unchanged, no resp_valid, req_ready=1 after release.
- With LSU_STATS_EN, run 3 loads, 2 stores and 1 misaligned op -> stat_loads=3, stat_stores=2, stat_errs=1. Without the macro, all three read 0.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: bundle of the request/response handshake and the word-wide
// memory port that surround the load/store unit.
//   req_*   : MEM-stage request (valid/ready handshake, op, byte address, data)
//   resp_*  : one-cycle completion pulse with load data and misalign flag
//   mem_*   : word-only data memory port (read/write enables, word address,
//             write data, combinational read data)
// Modports:
//   slave  : the load/store unit itself
//   master : the surrounding environment (requester plus memory)
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit in front of a word-only data memory.
// Accepts LB/LBU/LH/LHU/LW/SB/SH/SW, extracts and extends load lanes, merges
// sub-word stores via read-modify-write and rejects misaligned accesses.
// Ports:
//   CLK, RST_N       : clock (rising edge), asynchronous active-low reset
//   bus (slave)      : request handshake, response pulse, memory port
//   stat_loads/stat_stores/stat_errs : completion counters
// Optional build macro LSU_STATS_EN: when defined the three counters are
// built; otherwise they are tied to 0.
//
// state  | meaning
// IDLE   | ready for a request
// RD     | memory read for a load, lane captured into resp_rdata
// RMW_RD | memory read for SB/SH, lane merged into the merge register
// WR     | memory write of the merge register
// RESP   | one-cycle response pulse
module dmem_lsu #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  dmem_lsu_if.slave         bus,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  // Only the lane offset of the address is needed after accept; the word
  // address lives in mem_addr_q.
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              misaligned;
  logic [4:0]        shamt;
  logic [15:0]       rd_lane;
  logic [31:0]       ld_data;
  logic [31:0]       ins_mask;
  logic [31:0]       merged;

  always_comb begin
    unique case (bus.req_op)
      OP_LH, OP_LHU, OP_SH: misaligned = bus.req_addr[0];
      OP_LW, OP_SW:         misaligned = (bus.req_addr[1:0] != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end

  // Low 16 bits of the read word after shifting the addressed lane to bit 0.
  assign shamt   = {addr_lo_q, 3'b000};
  assign rd_lane = 16'(bus.mem_rdata >> shamt);

  always_comb begin
    unique case (op_q)
      OP_LB:   ld_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
      OP_LBU:  ld_data = {24'h0, rd_lane[7:0]};
      OP_LH:   ld_data = {{16{rd_lane[15]}}, rd_lane};
      OP_LHU:  ld_data = {16'h0, rd_lane};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  // Store data is right-aligned; shift it into the addressed lane and keep
  // the untouched lanes from the memory read.
  always_comb begin
    ins_mask = (op_q == OP_SH) ? (32'h0000_FFFF << shamt) : (32'h0000_00FF << shamt);
    merged   = (bus.mem_rdata & ~ins_mask) | ((wdata_q << shamt) & ins_mask);
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    mem_addr_d   = mem_addr_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d         = bus.req_op;
          addr_lo_d    = bus.req_addr[1:0];
          wdata_d      = bus.req_wdata;
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b0;
          if (misaligned) begin
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end else begin
            mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (bus.req_op <= OP_LW) begin
              state_d = S_RD;
            end else if (bus.req_op == OP_SW) begin
              merge_d = bus.req_wdata;
              state_d = S_WR;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_RD: begin
        resp_rdata_d = ld_data;
        state_d      = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = merged;
        state_d = S_WR;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      addr_lo_q    <= 2'd0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      mem_addr_q   <= '0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      mem_addr_q   <= mem_addr_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // All memory-side outputs come from registered state, so reset drops
  // mem_we without waiting for a clock edge.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_re     = (state_q == S_RD) || (state_q == S_RMW_RD);
  assign bus.mem_we     = (state_q == S_WR);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = merge_q;

`ifdef LSU_STATS_EN
  logic [STAT_W-1:0] stat_loads_q, stat_loads_d;
  logic [STAT_W-1:0] stat_stores_q, stat_stores_d;
  logic [STAT_W-1:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (state_q == S_RESP) begin
      if (resp_err_q)        stat_errs_d   = stat_errs_q + 1'b1;
      else if (op_q >= OP_SB) stat_stores_d = stat_stores_q + 1'b1;
      else                   stat_loads_d  = stat_loads_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errs   = '0;
`endif

endmodule
